// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_W  = 6;
  localparam int unsigned FETCH_INSTR_W = 16;
  localparam int unsigned FETCH_DEPTH   = 2;

  typedef logic [FETCH_ADDR_W-1:0]  addr_t;
  typedef logic [FETCH_INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

  // True when the buffer still has room after this cycle's push/pop.
  function automatic logic can_accept(input logic [1:0] count,
                                      input logic       push,
                                      input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    return occ < 3'(FETCH_DEPTH);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO; slot 0 is always the head, so the head
// outputs keep their last value once the buffer empties.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [ADDR_W-1:0]  i_push_pc,
  input  logic [INSTR_W-1:0] i_push_instr,
  input  logic               i_pop,
  output logic [1:0]         o_count,
  output logic [ADDR_W-1:0]  o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr
);

  logic [ADDR_W-1:0]  r_pc    [FETCH_DEPTH];
  logic [INSTR_W-1:0] r_instr [FETCH_DEPTH];
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'(FETCH_DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc[0]    <= i_push_pc;
            r_instr[0] <= i_push_instr;
          end else begin
            r_pc[1]    <= i_push_pc;
            r_instr[1] <= i_push_instr;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves slot 0 untouched so the head holds.
          if (r_count == 2'd2) begin
            r_pc[0]    <= r_pc[1];
            r_instr[0] <= r_instr[1];
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_pc[0]    <= r_pc[1];
            r_instr[0] <= r_instr[1];
            r_pc[1]    <= i_push_pc;
            r_instr[1] <= i_push_instr;
          end else begin
            r_pc[0]    <= i_push_pc;
            r_instr[0] <= i_push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pc[0];
  assign o_head_instr = r_instr[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one read at a time to instruction memory
// and buffers returned words for decode; a flush drops buffered and in-flight data.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_req_pc;

  logic [1:0] w_count;
  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  logic       w_issue_state;
  logic       w_issue;

  assign w_valid       = (w_count != 2'd0);
  assign w_pop         = w_valid & instr_ready & ~flush;
  assign w_push        = (r_state == S_WAIT) & imem_rvalid & ~flush;
  assign w_issue_state = (r_state == S_FETCH) | ((r_state == S_WAIT) & imem_rvalid);
  // Reset also suppresses the request so no read leaves while rst is low.
  assign w_issue       = rst & ~flush & w_issue_state & can_accept(w_count, w_push, w_pop);

  assign imem_rd     = w_issue;
  assign pc_advance  = w_issue;
  assign imem_addr   = w_issue ? pc : '0;
  assign instr_valid = w_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_req_pc <= '0;
    end else begin
      if (w_issue) begin
        r_req_pc <= pc;
      end
      case (r_state)
        S_FETCH: begin
          if (w_issue) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid)  r_state <= w_issue ? S_WAIT : S_FETCH;
          else if (flush)   r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (imem_rvalid) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_push_pc   (r_req_pc),
    .i_push_instr(imem_rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_pc   (instr_pc),
    .o_head_instr(instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table, a queue-based
// reference model under random stimulus, and a throughput count per latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pc;
  logic        pc_advance;
  logic        imem_rd;
  logic [5:0]  imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [5:0]  instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(6), .INSTR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_advance (pc_advance),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  pc;
    logic        rvalid;
    logic [15:0] rdata;
    logic        flush;
    logic        ready;
    logic        e_rd;
    logic [5:0]  e_addr;
    logic        e_adv;
    logic        e_valid;
    logic        chk_head;
    logic [15:0] e_instr;
    logic [5:0]  e_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [5:0] p, logic rv, logic [15:0] rd, logic fl,
                              logic rdy, logic erd, logic [5:0] ea, logic eadv, logic ev,
                              logic ch, logic [15:0] ei, logic [5:0] eip);
    vec_t v;
    v.rst = r; v.pc = p; v.rvalid = rv; v.rdata = rd; v.flush = fl; v.ready = rdy;
    v.e_rd = erd; v.e_addr = ea; v.e_adv = eadv; v.e_valid = ev;
    v.chk_head = ch; v.e_instr = ei; v.e_ipc = eip;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; pc = '0; imem_rvalid = 1'b0; imem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference model: queue of {pc, instr}, plus one outstanding-read slot.
  logic [21:0] mq[$];
  bit          m_out;
  bit          m_keep;
  logic [5:0]  m_req_pc;

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_keep = 0; m_req_pc = '0;
  endtask

  task automatic run_model(input int cyc, input logic rv, input logic [15:0] rdat, input logic fl,
                           input logic rdy, input logic [5:0] pcv, output bit e_issue);
    bit   e_valid, pop, push, st_ok;
    int   occ;
    e_valid = (mq.size() != 0);
    pop     = e_valid && rdy && !fl;
    push    = m_out && m_keep && rv && !fl;
    st_ok   = !m_out || (m_keep && rv);
    occ     = mq.size() + int'(push) - int'(pop);
    e_issue = !fl && (occ < 2) && st_ok;
    chk("imem_rd", cyc, 32'(imem_rd), 32'(e_issue));
    chk("pc_advance", cyc, 32'(pc_advance), 32'(e_issue));
    chk("imem_addr", cyc, 32'(imem_addr), e_issue ? 32'(pcv) : 32'd0);
    chk("instr_valid", cyc, 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      chk("instr", cyc, 32'(instr), 32'(mq[0][15:0]));
      chk("instr_pc", cyc, 32'(instr_pc), 32'(mq[0][21:16]));
    end
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({m_req_pc, rdat});
    end
    if (m_out && rv) m_out = 0;
    else if (m_out && fl) m_keep = 0;
    if (e_issue) begin
      m_out = 1; m_keep = 1; m_req_pc = pcv;
    end
  endtask

  task automatic run_random(input int lat, input int ncyc, input bit rnd);
    bit         pending = 0;
    int         cnt = 0;
    logic [5:0] p_pc;
    bit         e_issue;
    int         pops = 0;
    logic       rv;
    do_reset();
    model_reset();
    p_pc = rnd ? 6'($urandom) : 6'd0;
    for (int c = 0; c < ncyc; c++) begin
      rst = 1'b1;
      if (pending && cnt > 0) cnt--;
      rv = pending && (cnt == 0);
      if (rnd && !pending && !m_out && $urandom_range(0, 15) == 0) rv = 1'b1;
      imem_rvalid = rv;
      imem_rdata  = rnd ? 16'($urandom) : 16'h1000 + 16'(dut.r_req_pc === 'x ? 0 : 0) + 16'(m_req_pc);
      flush       = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
      instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pc          = p_pc;
      @(negedge clk);
      if (instr_valid && instr_ready) pops++;
      run_model(c, imem_rvalid, imem_rdata, flush, instr_ready, pc, e_issue);
      if (rv && pending) pending = 0;
      if (e_issue) begin
        pending = 1; cnt = lat;
      end
      p_pc = flush ? 6'($urandom) : (e_issue ? p_pc + 6'd1 : p_pc);
      @(posedge clk);
      #1;
    end
    if (!rnd) chk("throughput", lat, 32'(pops), 32'((ncyc - 2 - lat) / lat + 1));
  endtask

  initial begin
    vecs.push_back(mk(0, 6'h00, 0, 16'h0000, 0, 0,  0, 6'h00, 0, 0, 1, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h00, 0, 16'h0000, 0, 0,  1, 6'h00, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h01, 1, 16'h1000, 0, 0,  1, 6'h01, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h02, 1, 16'h1001, 0, 0,  0, 6'h00, 0, 1, 1, 16'h1000, 6'h00));
    vecs.push_back(mk(1, 6'h02, 0, 16'h0000, 0, 0,  0, 6'h00, 0, 1, 1, 16'h1000, 6'h00));
    vecs.push_back(mk(1, 6'h02, 0, 16'h0000, 0, 1,  1, 6'h02, 1, 1, 1, 16'h1000, 6'h00));
    vecs.push_back(mk(1, 6'h03, 1, 16'h1002, 0, 1,  1, 6'h03, 1, 1, 1, 16'h1001, 6'h01));
    vecs.push_back(mk(1, 6'h04, 1, 16'h1003, 0, 1,  1, 6'h04, 1, 1, 1, 16'h1002, 6'h02));
    vecs.push_back(mk(1, 6'h05, 1, 16'h1004, 1, 1,  0, 6'h00, 0, 1, 1, 16'h1003, 6'h03));
    vecs.push_back(mk(1, 6'h20, 0, 16'h0000, 0, 1,  1, 6'h20, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h21, 1, 16'h1020, 0, 1,  1, 6'h21, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h22, 1, 16'h1021, 0, 1,  1, 6'h22, 1, 1, 1, 16'h1020, 6'h20));
    vecs.push_back(mk(1, 6'h23, 0, 16'h0000, 1, 1,  0, 6'h00, 0, 1, 1, 16'h1021, 6'h21));
    vecs.push_back(mk(1, 6'h20, 0, 16'h0000, 0, 1,  0, 6'h00, 0, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h20, 1, 16'hDEAD, 0, 1,  0, 6'h00, 0, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h20, 0, 16'h0000, 0, 1,  1, 6'h20, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h21, 1, 16'h1020, 0, 1,  1, 6'h21, 1, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h22, 0, 16'h0000, 0, 1,  0, 6'h00, 0, 1, 1, 16'h1020, 6'h20));
    vecs.push_back(mk(0, 6'h22, 0, 16'h0000, 0, 1,  0, 6'h00, 0, 0, 0, 16'h0000, 6'h00));
    vecs.push_back(mk(0, 6'h22, 1, 16'hBEEF, 0, 1,  0, 6'h00, 0, 0, 1, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h05, 1, 16'hBEEF, 0, 0,  1, 6'h05, 1, 0, 1, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h06, 0, 16'h0000, 0, 0,  0, 6'h00, 0, 0, 1, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h06, 1, 16'h1005, 0, 0,  1, 6'h06, 1, 0, 1, 16'h0000, 6'h00));
    vecs.push_back(mk(1, 6'h07, 1, 16'h1006, 0, 0,  0, 6'h00, 0, 1, 1, 16'h1005, 6'h05));
    vecs.push_back(mk(1, 6'h07, 0, 16'h0000, 0, 0,  0, 6'h00, 0, 1, 1, 16'h1005, 6'h05));

    do_reset();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; pc = vecs[i].pc; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; flush = vecs[i].flush; instr_ready = vecs[i].ready;
      @(negedge clk);
      chk("vec_rd", i, 32'(imem_rd), 32'(vecs[i].e_rd));
      chk("vec_addr", i, 32'(imem_addr), 32'(vecs[i].e_addr));
      chk("vec_adv", i, 32'(pc_advance), 32'(vecs[i].e_adv));
      chk("vec_valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_head) begin
        chk("vec_instr", i, 32'(instr), 32'(vecs[i].e_instr));
        chk("vec_ipc", i, 32'(instr_pc), 32'(vecs[i].e_ipc));
      end
      @(posedge clk);
      #1;
    end

    for (int lat = 1; lat <= 3; lat++) run_random(lat, 30, 1'b0);
    for (int lat = 1; lat <= 3; lat++) run_random(lat, 400, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
